// File: rtl/sbio_tx_arbiter_if.sv
// Bus bundle between the two message requesters / receive side and the sbio
// transmit arbiter. The master side drives requests; the slave side is the arbiter.
interface sbio_tx_arbiter_if #(
    parameter int IO_BITS      = 2,
    parameter int PAYLOAD_BITS = 16
);
    logic [1:0]              req;
    logic [PAYLOAD_BITS-1:0] data0;
    logic [PAYLOAD_BITS-1:0] data1;
    logic                    rx_busy;
    logic [1:0]              ack;
    logic [IO_BITS-1:0]      tx_pins;
    logic                    tx_oe;
    logic                    busy;
    logic                    grant_id;

    modport master (
        output req, data0, data1, rx_busy,
        input  ack, tx_pins, tx_oe, busy, grant_id
    );

    modport slave (
        input  req, data0, data1, rx_busy,
        output ack, tx_pins, tx_oe, busy, grant_id
    );
endinterface

// File: rtl/sbio_tx_arbiter.sv
// Two-requester arbiter for the half-duplex sbio transmit port: grants one message,
// then drives a start cycle and PAYLOAD_BITS/IO_BITS data cycles, LSB chunk first.
// Optional feature macro: SBIO_TX_ROUND_ROBIN_EN (round-robin tie break; default fixed priority).
module sbio_tx_arbiter #(
    parameter int IO_BITS      = 2,
    parameter int PAYLOAD_BITS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    sbio_tx_arbiter_if.slave  bus
);

    localparam int NCYC  = PAYLOAD_BITS / IO_BITS;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [PAYLOAD_BITS-1:0] shift_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [IO_BITS-1:0]      tx_pins_r;
    logic                    tx_oe_r;
    logic                    grant_id_r;
`ifdef SBIO_TX_ROUND_ROBIN_EN
    logic                    rr_r;
`endif

    logic                    grant_window_s;
    logic                    grant_ok_s;
    logic                    winner_s;
    logic [1:0]              ack_s;
    logic [PAYLOAD_BITS-1:0] win_data_s;

    // Start word: bit0 marks the frame, bit1 carries the requester id, rest zero.
    function automatic logic [IO_BITS-1:0] start_word(input logic id);
        logic [IO_BITS-1:0] w;
        w    = {IO_BITS{1'b0}};
        w[0] = 1'b1;
        w[1] = id;
        return w;
    endfunction

    // Winner selection among pending requests.
    always_comb begin
        winner_s = 1'b0;
`ifdef SBIO_TX_ROUND_ROBIN_EN
        if (bus.req == 2'b11) begin
            winner_s = rr_r;
        end else if (bus.req[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
`else
        if (bus.req[0]) begin
            winner_s = 1'b0;
        end else if (bus.req[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
`endif
    end

    // A grant may only land when the port is idle or on the last data cycle.
    always_comb begin
        grant_window_s = 1'b0;
        case (state_r)
            ST_IDLE:  grant_window_s = 1'b1;
            ST_SEND:  grant_window_s = (cnt_r == LAST_CNT);
            ST_START: grant_window_s = 1'b0;
            default:  grant_window_s = 1'b0;
        endcase
    end

    // Combinational acknowledge; forced low while reset is asserted.
    always_comb begin
        grant_ok_s = reset_n && (|bus.req) && !bus.rx_busy && grant_window_s;
        ack_s      = 2'b00;
        win_data_s = bus.data0;
        if (winner_s) begin
            win_data_s = bus.data1;
        end else begin
            win_data_s = bus.data0;
        end
        if (grant_ok_s) begin
            ack_s = winner_s ? 2'b10 : 2'b01;
        end else begin
            ack_s = 2'b00;
        end
    end

    // Frame sequencer with registered pad outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            shift_r    <= {PAYLOAD_BITS{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            tx_pins_r  <= {IO_BITS{1'b0}};
            tx_oe_r    <= 1'b0;
            grant_id_r <= 1'b0;
`ifdef SBIO_TX_ROUND_ROBIN_EN
            rr_r       <= 1'b0;
`endif
        end else if (grant_ok_s) begin
            state_r    <= ST_START;
            shift_r    <= win_data_s;
            cnt_r      <= {CNT_W{1'b0}};
            tx_pins_r  <= start_word(winner_s);
            tx_oe_r    <= 1'b1;
            grant_id_r <= winner_s;
`ifdef SBIO_TX_ROUND_ROBIN_EN
            rr_r       <= !winner_s;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_pins_r <= {IO_BITS{1'b0}};
                    tx_oe_r   <= 1'b0;
                end
                ST_START: begin
                    // Pins run one chunk behind the shifter, so pop the first chunk now.
                    state_r   <= ST_SEND;
                    cnt_r     <= {CNT_W{1'b0}};
                    tx_pins_r <= shift_r[IO_BITS-1:0];
                    shift_r   <= shift_r >> IO_BITS;
                    tx_oe_r   <= 1'b1;
                end
                ST_SEND: begin
                    if (cnt_r == LAST_CNT) begin
                        state_r   <= ST_IDLE;
                        cnt_r     <= {CNT_W{1'b0}};
                        tx_pins_r <= {IO_BITS{1'b0}};
                        tx_oe_r   <= 1'b0;
                    end else begin
                        cnt_r     <= cnt_r + CNT_W'(1);
                        tx_pins_r <= shift_r[IO_BITS-1:0];
                        shift_r   <= shift_r >> IO_BITS;
                        tx_oe_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= {CNT_W{1'b0}};
                    tx_pins_r <= {IO_BITS{1'b0}};
                    tx_oe_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack      = ack_s;
    assign bus.tx_pins  = tx_pins_r;
    assign bus.tx_oe    = tx_oe_r;
    assign bus.grant_id = grant_id_r;
    assign bus.busy     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sbio_tx_arbiter.sv
// Directed bench for sbio_tx_arbiter with IO_BITS=2, PAYLOAD_BITS=8 (4 data cycles).
// Tie-break expectations follow SBIO_TX_ROUND_ROBIN_EN when the build defines it.
module tb_sbio_tx_arbiter;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    sbio_tx_arbiter_if #(.IO_BITS(2), .PAYLOAD_BITS(8)) bus ();

    sbio_tx_arbiter #(.IO_BITS(2), .PAYLOAD_BITS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-split payload chunks, LSB pair first.
    logic [1:0] exp_b4 [4] = '{2'd0, 2'd1, 2'd3, 2'd2};   // 8'hB4 = 10_11_01_00
    logic [1:0] exp_5a [4] = '{2'd2, 2'd2, 2'd1, 2'd1};   // 8'h5A = 01_01_10_10
    logic [1:0] exp_3c [4] = '{2'd0, 2'd3, 2'd3, 2'd0};   // 8'h3C = 00_11_11_00
    logic [1:0] exp_e1 [4] = '{2'd1, 2'd0, 2'd2, 2'd3};   // 8'hE1 = 11_10_00_01

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.req     = 2'b11;
        bus.data0   = 8'h00;
        bus.data1   = 8'h00;
        bus.rx_busy = 1'b0;
        tick();
        #1;
        n_checks++; if (bus.ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack got=%b exp=00", bus.ack); end
        n_checks++; if (bus.tx_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", bus.tx_oe); end
        n_checks++; if (bus.tx_pins !== 2'b00) begin n_fail++; $display("FAIL reset_pins got=%b exp=00", bus.tx_pins); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_gid got=%b exp=0", bus.grant_id); end
        tick();
        bus.req = 2'b00;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        tick();
        bus.data0 = 8'hB4;
        bus.req   = 2'b01;
        #1;
        n_checks++; if (bus.ack !== 2'b01) begin n_fail++; $display("FAIL single_ack got=%b exp=01", bus.ack); end
        tick();
        bus.req = 2'b00;
        #1;
        n_checks++; if (bus.tx_pins !== 2'b01) begin n_fail++; $display("FAIL single_start got=%b exp=01", bus.tx_pins); end
        n_checks++; if (bus.tx_oe !== 1'b1) begin n_fail++; $display("FAIL single_start_oe got=%b exp=1", bus.tx_oe); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
        n_checks++; if (bus.grant_id !== 1'b0) begin n_fail++; $display("FAIL single_gid got=%b exp=0", bus.grant_id); end
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            n_checks++; if (bus.tx_pins !== exp_b4[k]) begin n_fail++; $display("FAIL single_data%0d got=%b exp=%b", k, bus.tx_pins, exp_b4[k]); end
            n_checks++; if (bus.tx_oe !== 1'b1) begin n_fail++; $display("FAIL single_oe%0d got=%b exp=1", k, bus.tx_oe); end
        end
        tick();
        #1;
        n_checks++; if (bus.tx_oe !== 1'b0) begin n_fail++; $display("FAIL single_end_oe got=%b exp=0", bus.tx_oe); end
        n_checks++; if (bus.tx_pins !== 2'b00) begin n_fail++; $display("FAIL single_end_pins got=%b exp=00", bus.tx_pins); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_end_busy got=%b exp=0", bus.busy); end
    endtask

    task automatic test_blocked();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                bus.rx_busy = 1'b1;
                bus.data1   = 8'h3C;
                bus.req     = 2'b10;
            end
            #1;
            n_checks++; if (bus.ack !== 2'b00) begin n_fail++; $display("FAIL blocked_ack%0d got=%b exp=00", i, bus.ack); end
            n_checks++; if (bus.tx_oe !== 1'b0) begin n_fail++; $display("FAIL blocked_oe%0d got=%b exp=0", i, bus.tx_oe); end
        end
        tick();
        bus.rx_busy = 1'b0;
        #1;
        n_checks++; if (bus.ack !== 2'b10) begin n_fail++; $display("FAIL blocked_release_ack got=%b exp=10", bus.ack); end
        tick();
        bus.req = 2'b00;
        #1;
        n_checks++; if (bus.tx_pins !== 2'b11) begin n_fail++; $display("FAIL blocked_start got=%b exp=11", bus.tx_pins); end
        n_checks++; if (bus.grant_id !== 1'b1) begin n_fail++; $display("FAIL blocked_gid got=%b exp=1", bus.grant_id); end
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            n_checks++; if (bus.tx_pins !== exp_3c[k]) begin n_fail++; $display("FAIL blocked_data%0d got=%b exp=%b", k, bus.tx_pins, exp_3c[k]); end
        end
        tick();
        #1;
        n_checks++; if (bus.tx_oe !== 1'b0) begin n_fail++; $display("FAIL blocked_end_oe got=%b exp=0", bus.tx_oe); end
    endtask

    task automatic test_back_to_back();
        logic       id;
        logic       nid;
        logic [1:0] exp_ack;
        logic [1:0] exp_pins;
        tick();
        bus.data0 = 8'hB4;
        bus.data1 = 8'h5A;
        bus.req   = 2'b11;
        #1;
        n_checks++; if (bus.ack !== 2'b01) begin n_fail++; $display("FAIL tie_first_ack got=%b exp=01", bus.ack); end
        for (int f = 0; f < 4; f++) begin
`ifdef SBIO_TX_ROUND_ROBIN_EN
            id  = f[0];
            nid = ~f[0];
`else
            id  = 1'b0;
            nid = 1'b0;
`endif
            tick();
            #1;
            exp_pins = {id, 1'b1};
            n_checks++; if (bus.tx_pins !== exp_pins) begin n_fail++; $display("FAIL tie_start%0d got=%b exp=%b", f, bus.tx_pins, exp_pins); end
            n_checks++; if (bus.grant_id !== id) begin n_fail++; $display("FAIL tie_gid%0d got=%b exp=%b", f, bus.grant_id, id); end
            n_checks++; if (bus.ack !== 2'b00) begin n_fail++; $display("FAIL tie_start_ack%0d got=%b exp=00", f, bus.ack); end
            for (int k = 0; k < 4; k++) begin
                tick();
                if (f == 3 && k == 3) bus.req = 2'b00;
                #1;
                exp_pins = id ? exp_5a[k] : exp_b4[k];
                n_checks++; if (bus.tx_pins !== exp_pins) begin n_fail++; $display("FAIL tie_data%0d_%0d got=%b exp=%b", f, k, bus.tx_pins, exp_pins); end
                if (k == 3 && f != 3) exp_ack = nid ? 2'b10 : 2'b01;
                else exp_ack = 2'b00;
                n_checks++; if (bus.ack !== exp_ack) begin n_fail++; $display("FAIL tie_ack%0d_%0d got=%b exp=%b", f, k, bus.ack, exp_ack); end
            end
        end
        tick();
        #1;
        n_checks++; if (bus.tx_oe !== 1'b0) begin n_fail++; $display("FAIL tie_end_oe got=%b exp=0", bus.tx_oe); end
    endtask

    task automatic test_in_flight();
        tick();
        bus.data0 = 8'hE1;
        bus.req   = 2'b01;
        #1;
        n_checks++; if (bus.ack !== 2'b01) begin n_fail++; $display("FAIL inflight_ack got=%b exp=01", bus.ack); end
        tick();
        bus.req = 2'b00;
        #1;
        n_checks++; if (bus.tx_pins !== 2'b01) begin n_fail++; $display("FAIL inflight_start got=%b exp=01", bus.tx_pins); end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                bus.rx_busy = 1'b1;
                bus.data1   = 8'h5A;
                bus.req     = 2'b10;
            end
            #1;
            n_checks++; if (bus.tx_pins !== exp_e1[k]) begin n_fail++; $display("FAIL inflight_data%0d got=%b exp=%b", k, bus.tx_pins, exp_e1[k]); end
            n_checks++; if (bus.tx_oe !== 1'b1) begin n_fail++; $display("FAIL inflight_oe%0d got=%b exp=1", k, bus.tx_oe); end
            n_checks++; if (bus.ack !== 2'b00) begin n_fail++; $display("FAIL inflight_ack%0d got=%b exp=00", k, bus.ack); end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_checks++; if (bus.tx_oe !== 1'b0) begin n_fail++; $display("FAIL inflight_idle_oe%0d got=%b exp=0", i, bus.tx_oe); end
            n_checks++; if (bus.ack !== 2'b00) begin n_fail++; $display("FAIL inflight_hold_ack%0d got=%b exp=00", i, bus.ack); end
        end
        tick();
        bus.rx_busy = 1'b0;
        #1;
        n_checks++; if (bus.ack !== 2'b10) begin n_fail++; $display("FAIL inflight_release_ack got=%b exp=10", bus.ack); end
        tick();
        bus.req = 2'b00;
        #1;
        n_checks++; if (bus.tx_pins !== 2'b11) begin n_fail++; $display("FAIL inflight_start2 got=%b exp=11", bus.tx_pins); end
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            n_checks++; if (bus.tx_pins !== exp_5a[k]) begin n_fail++; $display("FAIL inflight_data2_%0d got=%b exp=%b", k, bus.tx_pins, exp_5a[k]); end
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        tick();
        bus.data0 = 8'hB4;
        bus.req   = 2'b01;
        #1;
        n_checks++; if (bus.ack !== 2'b01) begin n_fail++; $display("FAIL rstmid_ack got=%b exp=01", bus.ack); end
        tick();
        bus.req = 2'b00;
        tick();
        tick();
        tick();
        #1;
        n_checks++; if (bus.tx_pins !== exp_b4[2]) begin n_fail++; $display("FAIL rstmid_send2 got=%b exp=%b", bus.tx_pins, exp_b4[2]); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.tx_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe got=%b exp=0", bus.tx_oe); end
        n_checks++; if (bus.tx_pins !== 2'b00) begin n_fail++; $display("FAIL rstmid_pins got=%b exp=00", bus.tx_pins); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        tick();
        reset_n = 1'b1;
        tick();
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got=%b exp=0", bus.busy); end
        bus.data1 = 8'h5A;
        bus.req   = 2'b10;
        #1;
        n_checks++; if (bus.ack !== 2'b10) begin n_fail++; $display("FAIL rstmid_newack got=%b exp=10", bus.ack); end
        tick();
        bus.req = 2'b00;
        #1;
        n_checks++; if (bus.tx_pins !== 2'b11) begin n_fail++; $display("FAIL rstmid_start got=%b exp=11", bus.tx_pins); end
        n_checks++; if (bus.grant_id !== 1'b1) begin n_fail++; $display("FAIL rstmid_gid got=%b exp=1", bus.grant_id); end
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            n_checks++; if (bus.tx_pins !== exp_5a[k]) begin n_fail++; $display("FAIL rstmid_data%0d got=%b exp=%b", k, bus.tx_pins, exp_5a[k]); end
        end
        tick();
        #1;
        n_checks++; if (bus.tx_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_end_oe got=%b exp=0", bus.tx_oe); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_blocked();
        test_back_to_back();
        test_in_flight();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
